// File: rtl/jpeg_block_pingpong_ctrl.sv
// Double-buffered 8x8 block store controller: the producer fills one 64-word EBR bank
// while the consumer streams the other bank out in raster or transposed order.
module jpeg_block_pingpong_ctrl #(
  parameter int DW           = 32,
  parameter int AW           = 6,
  parameter bit RD_TRANSPOSE = 1'b0
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [DW-1:0] in_data_i,
  input  logic [3:0]    in_be_i,
  input  logic [AW-1:0] in_addr_i,
  input  logic          in_last_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [DW-1:0] out_data_o,
  output logic          out_last_o,
  output logic [1:0]    ram_wr_en_o,
  output logic [3:0]    ram_ben_o,
  output logic [AW-1:0] ram_wr_addr_o,
  output logic [DW-1:0] ram_wr_data_o,
  output logic [1:0]    ram_rd_en_o,
  output logic [AW-1:0] ram_rd_addr_o,
  input  logic [DW-1:0] ram0_rd_data_i,
  input  logic [DW-1:0] ram1_rd_data_i,
  output logic [1:0]    bank_full_o
);

  typedef enum logic [0:0] {ST_IDLE, ST_READ} state_t;

  state_t        state_reg, state_next;
  logic [1:0]    full_reg, full_next;
  logic          wb_reg, wb_next;
  logic          rb_reg, rb_next;
  logic [AW-1:0] rcnt_reg, rcnt_next;

  logic          infl_valid_reg, infl_bank_reg, infl_last_reg;

  logic [DW-1:0] fifo_data_reg [2];
  logic          fifo_last_reg [2];
  logic          wr_ptr_reg, rd_ptr_reg;
  logic [1:0]    count_reg;

  logic          wr_fire, commit, pop, push;
  logic          rd_active, space, issue, rcnt_last, release_bank;
  logic [1:0]    occ;
  logic [DW-1:0] push_data;

  // ---------------- write side ----------------
  assign in_ready_o    = ~full_reg[wb_reg];
  assign wr_fire       = in_valid_i & in_ready_o;
  assign commit        = wr_fire & in_last_i;
  assign ram_ben_o     = in_be_i;
  assign ram_wr_addr_o = in_addr_i;
  assign ram_wr_data_o = in_data_i;

  // ---------------- read side ----------------
  assign pop       = out_valid_o & out_ready_i;
  assign occ       = count_reg + {1'b0, infl_valid_reg};
  assign space     = pop ? (occ <= 2'd2) : (occ < 2'd2);
  // An idle reader issues in the same cycle it sees a committed bank, so the first
  // word reaches the FIFO two edges after the commit.
  assign rd_active    = (state_reg == ST_READ) | full_reg[rb_reg];
  assign issue        = rd_active & space;
  assign rcnt_last    = (rcnt_reg == {AW{1'b1}});
  assign release_bank = issue & rcnt_last;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      assign ram_wr_en_o[gi] = wr_fire & (wb_reg == 1'(gi));
      assign ram_rd_en_o[gi] = issue & (rb_reg == 1'(gi));
    end
    if (RD_TRANSPOSE) begin : g_transpose
      assign ram_rd_addr_o = {rcnt_reg[2:0], rcnt_reg[5:3]};
    end else begin : g_raster
      assign ram_rd_addr_o = rcnt_reg;
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    rb_next    = rb_reg;
    rcnt_next  = rcnt_reg;
    full_next  = full_reg;
    wb_next    = wb_reg;

    case (state_reg)
      ST_IDLE: if (full_reg[rb_reg]) state_next = ST_READ;
      ST_READ: state_next = ST_READ;
      default: state_next = ST_IDLE;
    endcase

    if (issue) begin
      rcnt_next = rcnt_reg + 1'b1;
      if (rcnt_last) begin
        rb_next    = ~rb_reg;
        state_next = full_reg[~rb_reg] ? ST_READ : ST_IDLE;
      end
    end

    // Release first so that a commit to the same bank would win.
    if (release_bank) full_next[rb_reg] = 1'b0;
    if (commit) begin
      full_next[wb_reg] = 1'b1;
      wb_next           = ~wb_reg;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg      <= ST_IDLE;
      full_reg       <= 2'b00;
      wb_reg         <= 1'b0;
      rb_reg         <= 1'b0;
      rcnt_reg       <= '0;
      infl_valid_reg <= 1'b0;
      infl_bank_reg  <= 1'b0;
      infl_last_reg  <= 1'b0;
    end else begin
      a_commit_release_same_bank: assert (!(commit && release_bank && (wb_reg == rb_reg)));
      state_reg      <= state_next;
      full_reg       <= full_next;
      wb_reg         <= wb_next;
      rb_reg         <= rb_next;
      rcnt_reg       <= rcnt_next;
      infl_valid_reg <= issue;
      infl_bank_reg  <= rb_reg;
      infl_last_reg  <= rcnt_last;
    end
  end

  // ---------------- output FIFO (2 entries) ----------------
  assign push      = infl_valid_reg;
  assign push_data = infl_bank_reg ? ram1_rd_data_i : ram0_rd_data_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fifo_data_reg[0] <= '0;
      fifo_data_reg[1] <= '0;
      fifo_last_reg[0] <= 1'b0;
      fifo_last_reg[1] <= 1'b0;
      wr_ptr_reg       <= 1'b0;
      rd_ptr_reg       <= 1'b0;
      count_reg        <= 2'd0;
    end else begin
      if (push) begin
        fifo_data_reg[wr_ptr_reg] <= push_data;
        fifo_last_reg[wr_ptr_reg] <= infl_last_reg;
        wr_ptr_reg                <= ~wr_ptr_reg;
      end
      if (pop) rd_ptr_reg <= ~rd_ptr_reg;
      count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
    end
  end

  assign out_valid_o = (count_reg != 2'd0);
  assign out_data_o  = fifo_data_reg[rd_ptr_reg];
  assign out_last_o  = fifo_last_reg[rd_ptr_reg];
  assign bank_full_o = full_reg;

endmodule

// File: tb/tb_jpeg_block_pingpong_ctrl.sv
// Bench for jpeg_block_pingpong_ctrl: a raster and a transposed instance share one
// stimulus stream; a block-level scoreboard predicts every streamed word.
module tb_jpeg_block_pingpong_ctrl;
  localparam int DW = 32;
  localparam int AW = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [3:0]    in_be = '0;
  logic [AW-1:0] in_addr = '0;

  logic          in_ready  [2];
  logic          out_valid [2];
  logic [DW-1:0] out_data  [2];
  logic          out_last  [2];
  logic [1:0]    wr_en     [2];
  logic [3:0]    ben       [2];
  logic [AW-1:0] wr_addr   [2];
  logic [DW-1:0] wr_data   [2];
  logic [1:0]    rd_en     [2];
  logic [AW-1:0] rd_addr   [2];
  logic [1:0]    bank_full [2];

  // instance 0 reads raster, instance 1 transposed; each has its own pair of EBR banks
  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    logic [DW-1:0] mem0 [64] = '{default: '0};
    logic [DW-1:0] mem1 [64] = '{default: '0};
    logic [DW-1:0] q0 = '0, q1 = '0;

    jpeg_block_pingpong_ctrl #(.DW(DW), .AW(AW), .RD_TRANSPOSE(1'(gi))) dut (
      .clk_i(clk), .rst_i(rst),
      .in_valid_i(in_valid), .in_ready_o(in_ready[gi]), .in_data_i(in_data),
      .in_be_i(in_be), .in_addr_i(in_addr), .in_last_i(in_last),
      .out_valid_o(out_valid[gi]), .out_ready_i(out_ready), .out_data_o(out_data[gi]),
      .out_last_o(out_last[gi]),
      .ram_wr_en_o(wr_en[gi]), .ram_ben_o(ben[gi]), .ram_wr_addr_o(wr_addr[gi]),
      .ram_wr_data_o(wr_data[gi]), .ram_rd_en_o(rd_en[gi]), .ram_rd_addr_o(rd_addr[gi]),
      .ram0_rd_data_i(q0), .ram1_rd_data_i(q1), .bank_full_o(bank_full[gi])
    );

    always @(posedge clk) begin
      for (int j = 0; j < 4; j++) begin
        if (wr_en[gi][0] && ben[gi][j]) mem0[wr_addr[gi]][8*j +: 8] <= wr_data[gi][8*j +: 8];
        if (wr_en[gi][1] && ben[gi][j]) mem1[wr_addr[gi]][8*j +: 8] <= wr_data[gi][8*j +: 8];
      end
      if (rd_en[gi][0]) q0 <= mem0[rd_addr[gi]];
      if (rd_en[gi][1]) q1 <= mem1[rd_addr[gi]];
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] mmem [2][64];   // what each bank holds
  logic [31:0] img  [8][64];   // ring of committed block images
  int          mwb, nblk;
  int          head [2], rpos [2], pops [2];
  logic [31:0] last_data [2];
  int          vectors = 0, miscompares = 0, cyc = 0, mode = 0;

  function automatic int ord(input int inst, input int k);
    return (inst == 1) ? (k % 8) * 8 + k / 8 : k;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bound_expired(input string tag);
    vectors++;
    miscompares++;
    $error("FAIL %s: observed no progress expected completion within bound", tag);
  endtask

  task automatic monitor();
    int b, a;
    if (rst) begin
      mwb = 0; nblk = 0;
      for (int i = 0; i < 2; i++) begin head[i] = 0; rpos[i] = 0; end
      return;
    end
    if (in_valid && in_ready[0]) begin
      for (int j = 0; j < 4; j++)
        if (in_be[j]) mmem[mwb][in_addr][8*j +: 8] = in_data[8*j +: 8];
      if (in_last) begin
        for (int k = 0; k < 64; k++) img[nblk % 8][k] = mmem[mwb][k];
        nblk++;
        mwb ^= 1;
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (out_valid[i] && out_ready) begin
        pops[i]++;
        if (head[i] >= nblk) begin
          vectors++;
          miscompares++;
          $error("FAIL pop_inst%0d: observed word %0h expected no output", i, out_data[i]);
        end else begin
          b = head[i] % 8;
          a = ord(i, rpos[i]);
          chk($sformatf("data_inst%0d_blk%0d_w%0d", i, head[i], rpos[i]), 64'(out_data[i]), 64'(img[b][a]));
          chk($sformatf("last_inst%0d_blk%0d_w%0d", i, head[i], rpos[i]), 64'(out_last[i]), 64'(rpos[i] == 63));
          last_data[i] = out_data[i];
          rpos[i]++;
          if (rpos[i] == 64) begin rpos[i] = 0; head[i]++; end
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
    case (mode)
      1: out_ready = ~out_ready;
      2: out_ready = 1'($urandom_range(0, 1));
      default: ;
    endcase
  endtask

  task automatic send_beat(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be, input logic last);
    int w = 0;
    in_valid = 1'b1; in_addr = a; in_data = d; in_be = be; in_last = last;
    while (!in_ready[0]) begin
      tick();
      w++;
      if (w > 400) begin bound_expired("in_ready_wait"); in_valid = 1'b0; return; end
    end
    tick();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // dmode 0: data = address, 1: constant fill, 2: random
  task automatic send_block(input int dmode, input logic [31:0] fill, input logic [3:0] be);
    logic [31:0] d;
    for (int k = 0; k < 64; k++) begin
      d = (dmode == 0) ? 32'(k) : (dmode == 1) ? fill : $urandom;
      send_beat(AW'(k), d, be, k == 63);
    end
  endtask

  task automatic wait_drain(input int limit);
    int t = 0;
    while (head[0] != nblk || head[1] != nblk) begin
      tick();
      t++;
      if (t > limit) begin bound_expired("drain"); return; end
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: observed no finish expected finish before 500us");
    $fatal(1);
  end

  initial begin : stim
    int t0, w, n;
    int p [2];
    for (int b = 0; b < 2; b++) for (int k = 0; k < 64; k++) mmem[b][k] = '0;
    for (int i = 0; i < 2; i++) begin pops[i] = 0; head[i] = 0; rpos[i] = 0; last_data[i] = '0; end
    mwb = 0; nblk = 0;

    // reset state
    rst = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_in_ready%0d", i), 64'(in_ready[i]), 64'(1));
      chk($sformatf("rst_out_valid%0d", i), 64'(out_valid[i]), 64'(0));
      chk($sformatf("rst_bank_full%0d", i), 64'(bank_full[i]), 64'(0));
      chk($sformatf("rst_rd_en%0d", i), 64'(rd_en[i]), 64'(0));
      chk($sformatf("rst_out_data%0d", i), 64'(out_data[i]), 64'(0));
    end
    rst = 1'b0;

    // raster / transpose with data = address, latency and throughput
    out_ready = 1'b1;
    send_block(0, '0, 4'hF);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("lat0_valid%0d", i), 64'(out_valid[i]), 64'(0));
      chk($sformatf("commit_full%0d", i), 64'(bank_full[i]), 64'(2'b01));
    end
    tick();
    for (int i = 0; i < 2; i++) chk($sformatf("lat1_valid%0d", i), 64'(out_valid[i]), 64'(0));
    tick();
    for (int i = 0; i < 2; i++) chk($sformatf("lat2_valid%0d", i), 64'(out_valid[i]), 64'(1));
    t0 = cyc;
    wait_drain(500);
    chk("stream_cycles", 64'(cyc - t0), 64'(64));
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("drained_full%0d", i), 64'(bank_full[i]), 64'(0));
      chk($sformatf("drained_ready%0d", i), 64'(in_ready[i]), 64'(1));
    end

    // ping-pong fill with the consumer stalled
    out_ready = 1'b0;
    send_block(2, '0, 4'hF);
    send_block(2, '0, 4'hF);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("pp_ready%0d", i), 64'(in_ready[i]), 64'(0));
      chk($sformatf("pp_full%0d", i), 64'(bank_full[i]), 64'(2'b11));
    end
    out_ready = 1'b1;
    repeat (61) tick();
    for (int i = 0; i < 2; i++) chk($sformatf("pp_ready_held%0d", i), 64'(in_ready[i]), 64'(0));
    tick();
    for (int i = 0; i < 2; i++) chk($sformatf("pp_ready_back%0d", i), 64'(in_ready[i]), 64'(1));
    send_block(2, '0, 4'hF);
    wait_drain(1000);

    // backpressure: consumer ready toggles every cycle
    for (int i = 0; i < 2; i++) p[i] = pops[i];
    mode = 1;
    send_block(2, '0, 4'hF);
    wait_drain(1000);
    mode = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) chk($sformatf("bp_pops%0d", i), 64'(pops[i] - p[i]), 64'(64));

    // byte enables: all-ones into both banks, then zeros on bytes 0 and 2
    send_block(1, 32'hFFFF_FFFF, 4'hF);
    send_block(1, 32'hFFFF_FFFF, 4'hF);
    wait_drain(1000);
    send_block(1, 32'h0000_0000, 4'h5);
    send_block(1, 32'h0000_0000, 4'h5);
    wait_drain(1000);
    for (int i = 0; i < 2; i++) chk($sformatf("be_word%0d", i), 64'(last_data[i]), 64'(32'hFF00_FF00));

    // random blocks: random length, address, byte enables, gaps and consumer ready
    mode = 2;
    for (int blk = 0; blk < 6; blk++) begin
      n = $urandom_range(1, 80);
      for (int b = 0; b < n; b++) begin
        repeat ($urandom_range(0, 2)) tick();
        send_beat(AW'($urandom), $urandom, 4'($urandom), b == n - 1);
      end
    end
    wait_drain(2000);
    mode = 0;
    out_ready = 1'b1;

    // reset in the middle of a read
    for (int i = 0; i < 2; i++) p[i] = pops[i];
    send_block(2, '0, 4'hF);
    w = 0;
    while (pops[0] - p[0] < 10 && w <= 200) begin tick(); w++; end
    if (w > 200) bound_expired("ten_pops");
    rst = 1'b1;
    out_ready = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("mid_rst_valid%0d", i), 64'(out_valid[i]), 64'(0));
      chk($sformatf("mid_rst_full%0d", i), 64'(bank_full[i]), 64'(0));
      chk($sformatf("mid_rst_ready%0d", i), 64'(in_ready[i]), 64'(1));
    end
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) p[i] = pops[i];
    send_block(2, '0, 4'hF);
    wait_drain(500);
    for (int i = 0; i < 2; i++) chk($sformatf("post_rst_pops%0d", i), 64'(pops[i] - p[i]), 64'(64));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/jpeg_block_pingpong_ctrl.md
Name: jpeg_block_pingpong_ctrl

Overview:
- Controller for a double-buffered 8x8 block store built from two 64x32 dual-port EBR banks with byte-wise write enables (bank 0, bank 1; read output unregistered, 1-cycle read latency).
- A producer (DCT/quant stage) fills one bank through a valid/ready write port, with a per-beat address and byte enables. A consumer drains the other bank in raster or transposed order through a valid/ready stream.
- Sits between the DCT and zigzag/entropy stages of the frame JPEG encoder.

Parameters:
- DW, 32, data width (must match EBR)
- AW, 6, bank address width (64 words)
- RD_TRANSPOSE, 0, 1 means read address = {cnt[2:0],cnt[5:3]}; 0 means read address = cnt

Ports:
- clk_i  in  1  single clock; also drives both EBR clocks
- rst_i  in  1  synchronous, active-high reset
- in_valid_i  in  1  write beat valid
- in_ready_o  out  1  write beat accepted when valid&ready
- in_data_i  in  DW  write data
- in_be_i  in  4  byte enables
- in_addr_i  in  AW  write word address
- in_last_i  in  1  final beat of block; commits current write bank
- out_valid_o  out  1  read stream valid
- out_ready_i  in  1  consumer ready
- out_data_o  out  DW  read data
- out_last_o  out  1  marks word 63 of a block
- ram_wr_en_o  out  2  per-bank write enable
- ram_ben_o  out  4  byte enables (shared)
- ram_wr_addr_o  out  AW  write address (shared)
- ram_wr_data_o  out  DW  write data (shared)
- ram_rd_en_o  out  2  per-bank read enable
- ram_rd_addr_o  out  AW  read address (shared)
- ram0_rd_data_i  in  DW  bank 0 read data
- ram1_rd_data_i  in  DW  bank 1 read data
- bank_full_o  out  2  status: bank holds a committed block

Behaviour:
- State: full[1:0], wb (write bank), rb (read bank), read FSM {IDLE, READ}, 6-bit rcnt, 1-deep in-flight tag (valid, bank, last), 2-entry output FIFO.
- Reset values: full=0, wb=0, rb=0, FSM=IDLE, rcnt=0, FIFO empty, in-flight tag cleared. All outputs 0 except in_ready_o=1. EBR contents are not cleared.
- Write side:
  - in_ready_o = !full[wb].
  - ram_wr_en_o[wb] = in_valid_i & in_ready_o, combinational; the other bank's bit is 0.
  - ram_ben_o, ram_wr_addr_o and ram_wr_data_o pass through unregistered.
- Commit: an accepted beat with in_last_i=1 sets full[wb] and toggles wb at that edge. in_last_i on any beat, including the first, commits the block. Unwritten words keep stale data.
- Read FSM:
  - IDLE -> READ when full[rb].
  - In READ, issue when space: (fifo_count + inflight - pop) < 2.
  - Issue drives ram_rd_en_o[rb]=1 and ram_rd_addr_o = f(rcnt), then rcnt++.
  - Issue at rcnt=63: clear full[rb], toggle rb, rcnt=0, and go to IDLE, or stay in READ if full[~rb] is already set. Back-to-back blocks run with no bubble.
- Read data: the in-flight tag records the bank and last flag. The cycle after an issue, the selected ramX_rd_data_i is pushed into the FIFO with last = (issued rcnt==63).
- Output:
  - out_valid_o = FIFO non-empty; out_data_o and out_last_o come from the FIFO head.
  - Pop when out_valid_o & out_ready_i.
  - Throughput is 1 word/clock with out_ready_i held high.
- Latency: out_valid_o first rises 2 edges after the edge that set full[rb] from an idle reader.
- Bank release: a bank is released at its final read issue. The producer can write it no earlier than the following edge, so there is never a same-address read/write in one cycle.
- Simultaneous commit (write side) and release (read side) on the same edge update independent full bits. If both target the same bank, set wins. That case is impossible for a legal state and is flagged by an assertion.
- Reset asserted mid-block discards the partial write, the pending read, in-flight data and the FIFO.

Test Plan:
- Raster, RD_TRANSPOSE=0: write addr 0..63 with data=addr, last on 63, out_ready=1 -> out_data 0..63 on consecutive cycles, first valid 2 edges after commit, out_last only on 63.
- Transpose, RD_TRANSPOSE=1: same data -> output sequence 0,8,16,...,56,1,9,...,63.
- Ping-pong fill: write 3 blocks with out_ready=0 -> in_ready drops after 2 commits, bank_full=2'b11; raise out_ready -> 128 words streamed, in_ready returns 1 cycle after bank 0 final issue.
- Backpressure: toggle out_ready 1/0 every cycle for a full block -> no lost or duplicated words, FIFO never exceeds 2, exactly 64 pops.
- Byte enables: write 0xFFFFFFFF with be=4'hF to all words, then 0x00000000 with be=4'h5 -> read 0xFF00FF00 per word.
- Reset mid-read after 10 pops -> next cycle out_valid=0, bank_full=0, in_ready=1; a new block then reads out cleanly from word 0.
